// File: rtl/image_frame_loader.sv
// Double-buffered image frame loader: writes 784-byte frames into the idle RAM bank and
// commits them after the 0x66/0xBB end markers. Optional pixel checksum: IMAGE_CHECKSUM_EN.
module image_frame_loader #(
    parameter int          IMAGE_SIZE     = 784,
    parameter int          ADDR_W         = 10,
    parameter logic [7:0]  END1           = 8'h66,
    parameter logic [7:0]  END2           = 8'hBB,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter int          TO_W           = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              inf_busy,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              active_bank,
    output logic              image_ready,
    output logic              frame_error,
    output logic              overrun,
    output logic [7:0]        err_count,
    output logic [15:0]       checksum
);

    typedef enum logic [1:0] {S_RECV, S_END1, S_END2, S_COMMIT} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_pix_cnt, w_pix_cnt_nxt;
    logic [TO_W-1:0]     r_to_cnt, w_to_cnt_nxt;
    logic                r_mem_we, w_mem_we_nxt;
    logic [ADDR_W:0]     r_mem_addr, w_mem_addr_nxt;
    logic [7:0]          r_mem_wdata, w_mem_wdata_nxt;
    logic                r_active_bank, w_active_bank_nxt;
    logic                r_image_ready, w_image_ready_nxt;
    logic                r_frame_error, w_frame_error_nxt;
    logic                r_overrun, w_overrun_nxt;
    logic [7:0]          r_err_count, w_err_count_nxt;

    logic w_last_pix, w_timed, w_timeout, w_marker_bad, w_abort, w_pix_we, w_commit;

    assign w_last_pix   = (r_pix_cnt == ADDR_W'(IMAGE_SIZE - 1));
    // Idle RECV with no pixels received is the only untimed waiting state besides COMMIT.
    assign w_timed      = (r_state == S_END1) || (r_state == S_END2) ||
                          ((r_state == S_RECV) && (r_pix_cnt != '0));
    assign w_timeout    = w_timed && !rx_ready && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_marker_bad = rx_ready && (((r_state == S_END1) && (rx_data != END1)) ||
                                       ((r_state == S_END2) && (rx_data != END2)));
    assign w_abort      = w_timeout || w_marker_bad;
    assign w_pix_we     = (r_state == S_RECV) && rx_ready;
    assign w_commit     = (r_state == S_COMMIT) && !inf_busy;

    // NOTE: synchronous reset lives inside the clocked block; all state uses non-blocking <=.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RECV;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RECV:   if (w_pix_we && w_last_pix) w_state_nxt = S_END1;
            S_END1: begin
                if (rx_ready)       w_state_nxt = (rx_data == END1) ? S_END2 : S_RECV;
                else if (w_timeout) w_state_nxt = S_RECV;
            end
            S_END2: begin
                if (rx_ready)       w_state_nxt = (rx_data == END2) ? S_COMMIT : S_RECV;
                else if (w_timeout) w_state_nxt = S_RECV;
            end
            S_COMMIT: if (!inf_busy) w_state_nxt = S_RECV;
            default:  w_state_nxt = S_RECV;
        endcase
    end

    always_comb begin
        w_pix_cnt_nxt     = r_pix_cnt;
        w_to_cnt_nxt      = '0;
        w_mem_we_nxt      = 1'b0;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_wdata_nxt   = r_mem_wdata;
        w_active_bank_nxt = r_active_bank;
        w_image_ready_nxt = 1'b0;
        w_frame_error_nxt = 1'b0;
        w_overrun_nxt     = 1'b0;
        w_err_count_nxt   = r_err_count;

        if (w_timed && !rx_ready && !w_timeout) begin
            w_to_cnt_nxt = r_to_cnt + 1'b1;
        end

        if (w_pix_we) begin
            w_mem_we_nxt    = 1'b1;
            w_mem_addr_nxt  = {~r_active_bank, r_pix_cnt};
            w_mem_wdata_nxt = rx_data;
            w_pix_cnt_nxt   = w_last_pix ? '0 : r_pix_cnt + 1'b1;
        end

        if (w_abort) begin
            w_frame_error_nxt = 1'b1;
            w_pix_cnt_nxt     = '0;
            if (r_err_count != 8'hFF) begin
                w_err_count_nxt = r_err_count + 1'b1;
            end
        end

        // A byte landing while a commit waits on the consumer is dropped, commit or not.
        if ((r_state == S_COMMIT) && rx_ready) begin
            w_overrun_nxt = 1'b1;
        end

        if (w_commit) begin
            w_active_bank_nxt = ~r_active_bank;
            w_image_ready_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_cnt     <= '0;
            r_to_cnt      <= '0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_active_bank <= 1'b0;
            r_image_ready <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_pix_cnt     <= w_pix_cnt_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_active_bank <= w_active_bank_nxt;
            r_image_ready <= w_image_ready_nxt;
            r_frame_error <= w_frame_error_nxt;
            r_overrun     <= w_overrun_nxt;
            r_err_count   <= w_err_count_nxt;
        end
    end

`ifdef IMAGE_CHECKSUM_EN
    logic [15:0] r_sum, r_checksum;

    // Pixel 0 restarts the sum, so a frame following an abort or reset starts clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum      <= '0;
            r_checksum <= '0;
        end else begin
            if (w_pix_we) begin
                r_sum <= ((r_pix_cnt == '0) ? 16'd0 : r_sum) + {8'd0, rx_data};
            end else if (w_abort) begin
                r_sum <= '0;
            end
            if (w_commit) begin
                r_checksum <= r_sum;
            end
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 16'd0;
`endif

    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign active_bank = r_active_bank;
    assign image_ready = r_image_ready;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;
    assign err_count   = r_err_count;

endmodule
